sonar_driver: RTL
=================

# sonar_driver

Ultrasonic range-finder front end (HC-SR04-class sensor) sitting directly below the control unit. It takes the control unit's one-cycle measure request and drives the sensor trigger pin. It times the echo pulse, converts the width to centimetres and returns an 8-bit distance with a one-cycle ready pulse. It also enforces the sensor's minimum re-trigger interval and reports missing or overlong echoes.

## Interface
- CYCLES_PER_CM, default 2900: clk cycles of echo width per centimetre (58 us at 50 MHz).
- TRIG_CYCLES, default 500: trigger pulse width in clk cycles (10 us at 50 MHz).
- TIMEOUT_CYCLES, default 1_500_000: maximum cycles in WAIT_ECHO, and maximum echo-high cycles (30 ms).
- HOLDOFF_CYCLES, default 3_000_000: minimum idle gap after a result before the next trigger (60 ms).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- measure  in  1  start request from the control unit; single-cycle pulse, sampled on clk.
- trig  out  1  sensor trigger pin; reset 0.
- echo  in  1  sensor echo pin; asynchronous to clk.
- ready  out  1  one-cycle pulse when a new distance is valid; reset 0.
- distance  out  8  last result in cm, saturated at 255; reset 0.
- no_echo  out  1  last result was a timeout; updated with ready; reset 0.
- busy  out  1  high in every state except IDLE; reset 0.

## Operation
- echo passes through a 2-flop synchronizer (echo_s). All edge detection and counting use echo_s.
- States:
  - IDLE: a measure pulse is accepted only here. It loads timer=0 and goes to TRIG. A measure pulse in any other state is dropped, not queued.
  - TRIG: trig=1 for exactly TRIG_CYCLES cycles, then trig=0 and go to WAIT_ECHO with timer=0.
  - WAIT_ECHO: when echo_s is high, go to ECHO with div=0, cm=0, timer=0. If timer reaches TIMEOUT_CYCLES first, finish with distance=255 and no_echo=1.
  - ECHO: each cycle with echo_s high, div increments. When div reaches CYCLES_PER_CM-1, div wraps to 0 and cm increments, saturating at 255.
    - echo_s low: finish with distance=cm and no_echo=0.
    - timer reaches TIMEOUT_CYCLES with echo_s still high: finish with distance=255 and no_echo=1.
  - HOLDOFF: entered on finish with timer=0. Stays until timer reaches HOLDOFF_CYCLES, then goes to IDLE.
- Finish means: in the same clock edge that enters HOLDOFF, register distance and no_echo and set ready=1 for one cycle.
- distance = floor(high_cycles / CYCLES_PER_CM), clamped to 255.
  - high_cycles is the number of clk cycles echo_s was high, counted from the first high cycle seen in WAIT_ECHO.
  - distance and no_echo hold their value until the next finish.
- timer width is clog2 of max(TRIG_CYCLES, TIMEOUT_CYCLES, HOLDOFF_CYCLES)+1. div width is clog2(CYCLES_PER_CM).
- echo already high on entry to WAIT_ECHO (stale echo) is treated as a valid rising edge.
- Reset mid-operation: all state returns to IDLE and every output returns to its reset value at once, including trig=0.

## Timing
- measure high at edge n: trig rises at edge n+1 and stays high TRIG_CYCLES cycles.
- Echo pin rises at edge r: echo_s is high from edge r+2, and ECHO is entered at edge r+3.
- Echo pin falls: ready is asserted 3 clk edges later, with distance valid in that same cycle.
- ready is high for exactly one cycle per accepted measure. It is never asserted without a preceding accepted measure.
- busy goes high the cycle after measure is accepted and stays high through HOLDOFF.
- Minimum spacing between trig rising edges is TRIG_CYCLES + HOLDOFF_CYCLES + 3 cycles.

## Test plan
Bench parameters: CYCLES_PER_CM=10, TRIG_CYCLES=4, TIMEOUT_CYCLES=4000, HOLDOFF_CYCLES=20.
- Normal measurement: measure pulse, echo high for 123 cycles 7 cycles after trig falls -> trig high for exactly 4 cycles; one ready pulse; distance=12; no_echo=0; busy falls 20 cycles after ready.
- Saturation: echo high for 3000 cycles -> distance=255, no_echo=0, ready once.
- No echo: echo held low -> ready 4000 cycles after entering WAIT_ECHO; distance=255; no_echo=1.
- Echo stuck high: echo high for 5000 cycles -> ready when the echo timer reaches 4000; distance=255; no_echo=1; the later echo fall has no effect.
- Request during busy or holdoff: measure pulses during TRIG, ECHO and HOLDOFF -> no extra trig and no extra ready; a measure in IDLE afterwards triggers normally.
- Reset mid-operation: rst_n low during TRIG and again during ECHO -> trig, ready, busy, distance and no_echo go to 0 immediately; the next measure runs a clean cycle, distance=12 for the 123-cycle echo.

Source files
------------

// File: rtl/sonar_driver.sv
// Front end for an HC-SR04-class ultrasonic ranger. It issues the trigger pulse,
// times the echo and returns a distance in cm, enforcing a re-trigger holdoff.
module sonar_driver #(
   parameter int CYCLES_PER_CM  = 2900,
   parameter int TRIG_CYCLES    = 500,
   parameter int TIMEOUT_CYCLES = 1_500_000,
   parameter int HOLDOFF_CYCLES = 3_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       measure,
   output logic       trig,
   input  logic       echo,
   output logic       ready,
   output logic [7:0] distance,
   output logic       no_echo,
   output logic       busy,
   output logic [2:0] dbg_state_o
);

   localparam int MAX_AB = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
   localparam int MAX_C  = (MAX_AB > HOLDOFF_CYCLES) ? MAX_AB : HOLDOFF_CYCLES;
   localparam int TW     = $clog2(MAX_C + 1);
   localparam int DW     = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

   localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLDOFF_CYCLES - 1);
   localparam logic [TW-1:0] T_ONE     = TW'(1);
   localparam logic [DW-1:0] DIV_LAST  = DW'(CYCLES_PER_CM - 1);
   localparam logic [DW-1:0] DIV_ONE   = DW'(1);
   // The WAIT_ECHO cycle that saw echo_s high is the first counted high cycle.
   localparam logic [DW-1:0] DIV_FIRST = (CYCLES_PER_CM > 1) ? DW'(1) : DW'(0);
   localparam logic [7:0]    CM_FIRST  = (CYCLES_PER_CM > 1) ? 8'd0 : 8'd1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_TRIG    = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_ECHO    = 3'd3;
   localparam logic [2:0] S_HOLDOFF = 3'd4;

   logic          echo_m_q, echo_s_q;
   logic [2:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [DW-1:0] div_q, div_d;
   logic [7:0]    cm_q, cm_d;
   logic          trig_q;
   logic          ready_q;
   logic [7:0]    dist_q;
   logic          no_echo_q;
   logic          finish;
   logic [7:0]    fin_dist;
   logic          fin_no_echo;

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q + T_ONE;
      div_d       = div_q;
      cm_d        = cm_q;
      finish      = 1'b0;
      fin_dist    = 8'd255;
      fin_no_echo = 1'b1;
      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (measure) state_d = S_TRIG;
         end
         S_TRIG: begin
            if (timer_q == TRIG_LAST) begin
               state_d = S_WAIT;
               timer_d = '0;
            end
         end
         S_WAIT: begin
            if (echo_s_q) begin
               state_d = S_ECHO;
               timer_d = '0;
               div_d   = DIV_FIRST;
               cm_d    = CM_FIRST;
            end else if (timer_q == TO_LAST) begin
               finish = 1'b1;
            end
         end
         S_ECHO: begin
            if (!echo_s_q) begin
               finish      = 1'b1;
               fin_dist    = cm_q;
               fin_no_echo = 1'b0;
            end else if (timer_q == TO_LAST) begin
               finish = 1'b1;
            end else if (div_q == DIV_LAST) begin
               div_d = '0;
               if (cm_q != 8'd255) cm_d = cm_q + 8'd1;
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end
         S_HOLDOFF: begin
            if (timer_q == HOLD_LAST) begin
               state_d = S_IDLE;
               timer_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
         end
      endcase
      if (finish) begin
         state_d = S_HOLDOFF;
         timer_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         echo_m_q  <= 1'b0;
         echo_s_q  <= 1'b0;
         state_q   <= S_IDLE;
         timer_q   <= '0;
         div_q     <= '0;
         cm_q      <= 8'd0;
         trig_q    <= 1'b0;
         ready_q   <= 1'b0;
         dist_q    <= 8'd0;
         no_echo_q <= 1'b0;
      end else begin
         echo_m_q <= echo;
         echo_s_q <= echo_m_q;
         state_q  <= state_d;
         timer_q  <= timer_d;
         div_q    <= div_d;
         cm_q     <= cm_d;
         // Registered from the current state, so trig rises one edge after acceptance.
         trig_q   <= (state_q == S_TRIG);
         ready_q  <= finish;
         if (finish) begin
            dist_q    <= fin_dist;
            no_echo_q <= fin_no_echo;
         end
      end
   end

   assign trig        = trig_q;
   assign ready       = ready_q;
   assign distance    = dist_q;
   assign no_echo     = no_echo_q;
   assign busy        = (state_q != S_IDLE);
   assign dbg_state_o = state_q;

endmodule
